// File: rtl/pipe_interlock_ctrl.sv
// Interlock and multi-cycle sequencing controller for a 5-stage pipeline.
// Computes the per-stage "result available" flags used by forwarding, stalls
// decode on unresolved producer/consumer hazards, sequences the iterative
// divider that sits in the exec stage, and counts stalled decode cycles.

module pipe_interlock_ctrl #(
    parameter int DIV_LAT = 8,   // divider busy cycles, must be >= 2
    parameter int CNT_W   = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    // decode stage
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_read,
    input  logic             id_rt_read,
    // exec stage
    input  logic             exe_valid,
    input  logic             exe_we,
    input  logic [4:0]       exe_dest,
    input  logic             exe_is_load,
    input  logic             exe_is_div,
    // mem stage
    input  logic             mem_allowin,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic             mem_is_load,
    input  logic [4:0]       mem_dest,
    input  logic             mem_data_ok,
    // writeback stage
    input  logic             wb_valid,
    input  logic             wb_we,
    // performance counter control
    input  logic             perf_clr,
    // outputs
    output logic             pipe3_finish,
    output logic             pipe4_finish,
    output logic             pipe5_finish,
    output logic             id_ready_go,
    output logic             exe_ready_go,
    output logic             div_start,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (DIV_LAT < 2) begin : g_bad_div_lat
            $error("pipe_interlock_ctrl: DIV_LAT must be at least 2");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("pipe_interlock_ctrl: CNT_W must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Divider FSM encoding and down-counter sizing
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW       = $clog2(DIV_LAT);
    // Loading DIV_LAT-1 and counting down through zero gives DIV_LAT
    // cycles in BUSY before the result is presented in DONE.
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          div_req;
    logic          div_done;

    // A divide is requesting service whenever a valid div sits in exec.
    assign div_req  = exe_valid & exe_is_div;
    assign div_done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Divider FSM next-state logic; flush overrides every transition
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; a missing
        // branch would otherwise infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Only reached again after the previous div was handed
                    // off, so the same div is never started twice.
                    if (div_req) begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // Hold the result until mem can take the instruction.
                    if (mem_allowin) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Divider FSM state and down-counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples the pre-edge values, independent of order.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Start pulse is combinational in the accepting IDLE cycle; it is held
    // low while reset is asserted so the divider never sees a stray start.
    assign div_start = resetn & (state == S_IDLE) & div_req & ~flush;
    assign div_busy  = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Per-stage result availability for forwarding
    // ------------------------------------------------------------------
    // Exec results are ready except for loads (data arrives in mem) and
    // divides that have not yet reached DONE.
    assign pipe3_finish = exe_valid & exe_we & ~exe_is_load &
                          (~exe_is_div | div_done);
    assign pipe4_finish = mem_valid & mem_we & (~mem_is_load | mem_data_ok);
    assign pipe5_finish = wb_valid & wb_we;

    assign exe_ready_go = ~exe_is_div | div_done;

    // ------------------------------------------------------------------
    // Decode operand hazard detection
    // ------------------------------------------------------------------
    // A stage blocks a consumer only if it will write a GPR but its value
    // is not yet forwardable. WB is always forwardable, so it never stalls.
    logic exe_pending;
    logic mem_pending;
    logic rs_hazard;
    logic rt_hazard;

    assign exe_pending = exe_valid & exe_we & ~pipe3_finish;
    assign mem_pending = mem_valid & mem_we & ~pipe4_finish;

    function automatic logic src_hazard(
        input logic       src_read,
        input logic [4:0] src,
        input logic       exe_pend,
        input logic [4:0] exe_rd,
        input logic       mem_pend,
        input logic [4:0] mem_rd
    );
        // Register $0 is hard-wired, so it can never carry a dependency.
        return src_read && (src != 5'd0) &&
               ((exe_pend && (exe_rd == src)) ||
                (mem_pend && (mem_rd == src)));
    endfunction

    assign rs_hazard = src_hazard(id_rs_read, id_rs, exe_pending, exe_dest,
                                  mem_pending, mem_dest);
    assign rt_hazard = src_hazard(id_rt_read, id_rt, exe_pending, exe_dest,
                                  mem_pending, mem_dest);

    // A flush kills the decode instruction anyway, so it must never wait.
    assign id_ready_go = ~(rs_hazard | rt_hazard) | flush;

    // ------------------------------------------------------------------
    // Saturating stalled-decode cycle counter
    // ------------------------------------------------------------------
    logic stall_now;
    logic cnt_sat;

    assign stall_now = id_valid & ~id_ready_go;
    assign cnt_sat   = &stall_cnt;

    // Counter: clear has priority, then increment until all-ones
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (stall_now && !cnt_sat) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_interlock_ctrl.md
Name: pipe_interlock_ctrl

Overview:
- Interlock and multi-cycle sequencing controller for the 5-stage pipeline.
- Computes per-stage "result available" flags (pipe3/4/5_finish) consumed by the forwarding-select logic.
- Stalls decode when a needed operand comes from a producer whose result is not yet available.
- Sequences the iterative divider occupying the exec stage; keeps a saturating stall-cycle performance counter.

Parameters:
- DIV_LAT, 8, divider busy cycles (>=2).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (exception/eret)
- id_valid  in  1  decode holds valid instruction
- id_rs, id_rt  in  5  source register numbers
- id_rs_read, id_rt_read  in  1  source actually read
- exe_valid, exe_we  in  1  exec valid, writes GPR
- exe_dest  in  5  exec destination
- exe_is_load, exe_is_div  in  1  exec op class
- mem_allowin  in  1  mem stage accepts this cycle
- mem_valid, mem_we, mem_is_load  in  1  mem stage info
- mem_dest  in  5  mem destination
- mem_data_ok  in  1  load data returned this cycle
- wb_valid, wb_we  in  1  wb stage info
- perf_clr  in  1  clear stall counter
- pipe3_finish, pipe4_finish, pipe5_finish  out  1  stage result available
- id_ready_go  out  1  decode may issue
- exe_ready_go  out  1  exec may hand off
- div_start  out  1  start pulse to divider
- div_busy  out  1  divider FSM not IDLE
- stall_cnt  out  CNT_W  stalled-decode cycle count

Behaviour:
- Reset (resetn=0, async): FSM=IDLE, counter=0, stall_cnt=0.
  - div_start=0, div_busy=0.
  - Combinational outputs follow their equations with FSM=IDLE.
- Divider FSM states: IDLE, BUSY, DONE; down-counter cnt, width clog2(DIV_LAT).
  - IDLE: if exe_valid & exe_is_div & !flush, then div_start=1 (same cycle, combinational), cnt<=DIV_LAT-1, go to BUSY.
  - BUSY: cnt decrements each cycle; at cnt==0 go to DONE. Result: exactly DIV_LAT cycles in BUSY.
  - DONE: hold until mem_allowin=1, then go to IDLE. No re-start of the same div: the IDLE check occurs only after hand-off.
  - flush in any state: next state IDLE, cnt<=0. Flush takes priority over all transitions.
- div_busy = (state!=IDLE).
- exe_ready_go = !exe_is_div | state==DONE.
- pipe3_finish = exe_valid & exe_we & !exe_is_load & (!exe_is_div | state==DONE).
- pipe4_finish = mem_valid & mem_we & (!mem_is_load | mem_data_ok).
- pipe5_finish = wb_valid & wb_we.
- rs hazard = id_rs_read & id_rs!=0 & ((exe_valid & exe_we & exe_dest==id_rs & !pipe3_finish) | (mem_valid & mem_we & mem_dest==id_rs & !pipe4_finish)).
  - rt hazard is identical with id_rt / id_rt_read.
  - WB never causes a stall.
- id_ready_go = !(rs hazard | rt hazard) | flush.
- stall_cnt: increments when id_valid & !id_ready_go; saturates at all-ones.
  - perf_clr has priority and sets it to 0 the next edge.
  - The counter keeps counting while the FSM is BUSY.
- Simultaneous events:
  - flush in the same cycle DONE sees mem_allowin: go to IDLE.
  - A second div already waiting in exec while in DONE with mem_allowin=1: go to IDLE first; it starts the following cycle.

Test Plan:
- Reset mid-BUSY (cnt=3): drop resetn → div_busy=0, stall_cnt=0 immediately; after release, a div in exec produces div_start=1 within 1 cycle.
- Div with DIV_LAT=8, mem_allowin=1: div_start high 1 cycle → div_busy high 9 cycles (8 BUSY + 1 DONE). exe_ready_go and pipe3_finish=1 only in the DONE cycle, then IDLE.
- Load-use: exe_is_load, exe_dest=5, id_rs=5 read → id_ready_go=0, stall_cnt+1.
  - Next cycle load in mem, mem_data_ok=0 → still stalled.
  - mem_data_ok=1 → pipe4_finish=1, id_ready_go=1.
- $0 source: id_rs=0 with exe_dest=0 load in exec → id_ready_go=1, stall_cnt unchanged.
- Flush during BUSY (cnt=4) → next cycle state IDLE, div_busy=0, no DONE. id_ready_go=1 during the flush cycle.
- Counter saturation with CNT_W=4: 20 stalled cycles → stall_cnt=15. perf_clr → 0 next cycle.
